// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch sequencer with branch-target LUT
// Optional RUN-cycle counter enabled by defining PC_FETCH_CYCLE_COUNT_EN.
module pc_fetch_unit #(
    parameter int A       = 10,
    parameter int W       = 9,
    parameter int LUT_IDX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic [W-1:0]       i_inst_in,
    input  logic               i_branch_taken,
    input  logic               i_branch_rel,
    input  logic [LUT_IDX-1:0] i_branch_idx,
    input  logic [7:0]         i_rel_offset,
    input  logic               i_lut_we,
    input  logic [LUT_IDX-1:0] i_lut_wr_idx,
    input  logic [A-1:0]       i_lut_wr_data,
    output logic [A-1:0]       o_inst_address,
    output logic               o_running,
    output logic               o_done,
    output logic [15:0]        o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int LUT_N = 2 ** LUT_IDX;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [A-1:0] r_pc;
    logic [A-1:0] w_pc_nxt;
    logic [A-1:0] r_lut [LUT_N];
    logic [A-1:0] w_rel_target;
    logic         w_halt_word;

    assign w_halt_word  = (i_inst_in == {W{1'b1}});
    assign w_rel_target = r_pc + {{(A-8){i_rel_offset[7]}}, i_rel_offset};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (!i_stall) begin
            case (r_state)
                S_IDLE: begin
                    w_pc_nxt = '0;
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_halt_word) begin
                        w_state_nxt = S_HALT;
                    end else if (i_branch_taken && i_branch_rel) begin
                        w_pc_nxt = w_rel_target;
                    end else if (i_branch_taken) begin
                        // Reads the pre-write entry when a same-index write lands this edge.
                        w_pc_nxt = r_lut[i_branch_idx];
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
                S_HALT: begin
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_pc_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LUT_N; i++) begin
                r_lut[i] <= '0;
            end
        end else if (i_lut_we) begin
            r_lut[i_lut_wr_idx] <= i_lut_wr_data;
        end
    end

`ifdef PC_FETCH_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_count <= '0;
        end else if (r_state != S_RUN && w_state_nxt == S_RUN) begin
            r_cycle_count <= '0;
        end else if (r_state == S_RUN && r_cycle_count != 16'hFFFF) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = 16'd0;
`endif

    assign o_inst_address = r_pc;
    assign o_running      = (r_state == S_RUN);
    assign o_done         = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - table-driven directed bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [8:0]  inst = 9'h000;
    logic        bt = 1'b0;
    logic        brel = 1'b0;
    logic [3:0]  bidx = 4'd0;
    logic [7:0]  off = 8'h00;
    logic        lwe = 1'b0;
    logic [3:0]  lidx = 4'd0;
    logic [9:0]  ldata = 10'd0;
    logic [9:0]  addr;
    logic        running;
    logic        done;
    logic [15:0] ccount;

    int n_vec  = 0;
    int n_fail = 0;

    pc_fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_stall        (stall),
        .i_inst_in      (inst),
        .i_branch_taken (bt),
        .i_branch_rel   (brel),
        .i_branch_idx   (bidx),
        .i_rel_offset   (off),
        .i_lut_we       (lwe),
        .i_lut_wr_idx   (lidx),
        .i_lut_wr_data  (ldata),
        .o_inst_address (addr),
        .o_running      (running),
        .o_done         (done),
        .o_cycle_count  (ccount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stall;
        logic [8:0] inst;
        logic       bt;
        logic       brel;
        logic [3:0] bidx;
        logic [7:0] off;
        logic       lwe;
        logic [3:0] lidx;
        logic [9:0] ldata;
        logic [9:0] exp_pc;
        logic       exp_run;
        logic       exp_done;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic s, input logic st, input logic [8:0] in,
                                input logic b, input logic r, input logic [3:0] bi,
                                input logic [7:0] o, input logic we, input logic [3:0] wi,
                                input logic [9:0] wd, input logic [9:0] pc,
                                input logic run, input logic dn);
        vec_t v;
        v.start = s; v.stall = st; v.inst = in; v.bt = b; v.brel = r; v.bidx = bi;
        v.off = o; v.lwe = we; v.lidx = wi; v.ldata = wd;
        v.exp_pc = pc; v.exp_run = run; v.exp_done = dn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [9:0] pc,
                               input logic run, input logic dn);
        check(name, {19'd0, addr, running, done, 1'b0}, {19'd0, pc, run, dn, 1'b0});
`ifndef PC_FETCH_CYCLE_COUNT_EN
        check({name, "_cc"}, {16'd0, ccount}, 32'd0);
`endif
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; inst = 9'h000; bt = 0; brel = 0; bidx = 0;
        off = 0; lwe = 0; lidx = 0; ldata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 st stl inst    bt rl idx off    we wi data     pc      run dn
        vecs[0]  = mk(1, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd0,   1, 0);
        vecs[1]  = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd1,   1, 0);
        vecs[2]  = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd2,   1, 0);
        vecs[3]  = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd3,   1, 0);
        vecs[4]  = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd4,   1, 0);
        vecs[5]  = mk(0, 1, 9'h1FF, 1, 1, 0, 8'h05, 0, 0, 10'h000, 10'd4,   1, 0);
        vecs[6]  = mk(0, 1, 9'h1FF, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd4,   1, 0);
        vecs[7]  = mk(0, 1, 9'h1FF, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd4,   1, 0);
        vecs[8]  = mk(0, 0, 9'h1FF, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd4,   0, 1);
        vecs[9]  = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd4,   0, 1);
        vecs[10] = mk(1, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd0,   1, 0);
        vecs[11] = mk(0, 0, 9'h000, 1, 1, 0, 8'h0A, 0, 0, 10'h000, 10'd10,  1, 0);
        vecs[12] = mk(0, 0, 9'h000, 1, 1, 0, 8'hFB, 0, 0, 10'h000, 10'd5,   1, 0);
        vecs[13] = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 1, 3, 10'h2A0, 10'd6,   1, 0);
        vecs[14] = mk(0, 0, 9'h000, 1, 0, 3, 8'h00, 1, 3, 10'h111, 10'h2A0, 1, 0);
        vecs[15] = mk(0, 0, 9'h000, 1, 0, 3, 8'h00, 0, 0, 10'h000, 10'h111, 1, 0);
        vecs[16] = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 1, 5, 10'd1020, 10'h112, 1, 0);
        vecs[17] = mk(0, 0, 9'h000, 1, 0, 5, 8'h00, 0, 0, 10'h000, 10'd1020, 1, 0);
        vecs[18] = mk(0, 0, 9'h000, 1, 1, 0, 8'h06, 0, 0, 10'h000, 10'd2,   1, 0);
        vecs[19] = mk(0, 0, 9'h000, 1, 1, 0, 8'h80, 0, 0, 10'h000, 10'd898, 1, 0);
        vecs[20] = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 1, 6, 10'h3FF, 10'd899, 1, 0);
        vecs[21] = mk(0, 0, 9'h000, 1, 0, 6, 8'h00, 0, 0, 10'h000, 10'd1023, 1, 0);
        vecs[22] = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd0,   1, 0);
        vecs[23] = mk(0, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd1,   1, 0);
        vecs[24] = mk(0, 0, 9'h000, 1, 1, 0, 8'h06, 0, 0, 10'h000, 10'd7,   1, 0);
        vecs[25] = mk(0, 0, 9'h1FF, 1, 1, 0, 8'h06, 0, 0, 10'h000, 10'd7,   0, 1);
        vecs[26] = mk(1, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd0,   1, 0);
        vecs[27] = mk(1, 0, 9'h000, 0, 0, 0, 8'h00, 0, 0, 10'h000, 10'd1,   1, 0);

        idle_inputs();
        #2;
        check_state("reset", 10'd0, 0, 0);
        @(negedge clk);
        rst = 0;
        step();
        check_state("idle_hold", 10'd0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            start = vecs[i].start; stall = vecs[i].stall; inst = vecs[i].inst;
            bt = vecs[i].bt; brel = vecs[i].brel; bidx = vecs[i].bidx; off = vecs[i].off;
            lwe = vecs[i].lwe; lidx = vecs[i].lidx; ldata = vecs[i].ldata;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_run, vecs[i].exp_done);
        end

        // Reach PC=300 via LUT[2], then reset between edges and confirm LUT was cleared.
        @(negedge clk);
        idle_inputs();
        lwe = 1; lidx = 2; ldata = 10'd300;
        step();
        @(negedge clk);
        idle_inputs();
        bt = 1; bidx = 2;
        step();
        check_state("pc300", 10'd300, 1, 0);
        idle_inputs();
        #2;
        rst = 1;
        #1;
        check_state("async_rst", 10'd0, 0, 0);
        @(negedge clk);
        rst = 0;
        start = 1;
        step();
        check_state("restart", 10'd0, 1, 0);
        @(negedge clk);
        idle_inputs();
        step();
        @(negedge clk);
        bt = 1; bidx = 2;
        step();
        check_state("lut_cleared", 10'd0, 1, 0);

`ifdef PC_FETCH_CYCLE_COUNT_EN
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        check("cc_reset", {16'd0, ccount}, 32'd0);
        @(negedge clk);
        rst = 0;
        start = 1;
        step();
        check("cc_start", {16'd0, ccount}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_inputs();
            step();
        end
        check("cc_run10", {16'd0, ccount}, 32'd10);
        @(negedge clk);
        inst = 9'h1FF;
        step();
        check("cc_halt", {16'd0, ccount}, 32'd11);
        check_state("cc_halted", 10'd10, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            step();
        end
        check("cc_frozen", {16'd0, ccount}, 32'd11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
